// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - per-channel press/release/long-press/auto-repeat pulse generator (auto-repeat enabled by BUTTON_AUTOREPEAT_EN)
module button_event_decoder #(
    parameter int WIDTH            = 1,
    parameter int TICK_CNT_MAX     = 125000,
    parameter int LONG_PRESS_TICKS = 1000,
    parameter int REPEAT_TICKS     = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held
);

    localparam int PW = $clog2(TICK_CNT_MAX) + 1;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam int HOLD_MAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
`else
    localparam int HOLD_MAX = LONG_PRESS_TICKS;
`endif
    localparam int CW = $clog2(HOLD_MAX) + 1;

    // Thresholds below 1 would make the counters wrap instead of hitting their target
    if (TICK_CNT_MAX < 1 || LONG_PRESS_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("button_event_decoder: TICK_CNT_MAX, LONG_PRESS_TICKS and REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    logic [PW-1:0]    presc_q;
    logic             tick;
    logic [WIDTH-1:0] prev_q;
    state_t           state_q [WIDTH];
    logic [CW-1:0]    cnt_q   [WIDTH];

    assign tick = (presc_q == PW'(TICK_CNT_MAX - 1));

    // Shared prescaler: one tick every TICK_CNT_MAX cycles keeps the per-channel counters narrow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    logic [WIDTH-1:0] repeat_q;
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = '0;
`endif

    // Per-channel FSM; release is checked first so it beats a coincident threshold tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q           <= '0;
            held             <= '0;
            press_pulse      <= '0;
            release_pulse    <= '0;
            long_press_pulse <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q         <= '0;
`endif
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q           <= debounced_signal;
            held             <= debounced_signal;
            press_pulse      <= '0;
            release_pulse    <= '0;
            long_press_pulse <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            repeat_q         <= '0;
`endif
            for (int i = 0; i < WIDTH; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (debounced_signal[i] && !prev_q[i]) begin
                            state_q[i]     <= PRESSED;
                            cnt_q[i]       <= '0;
                            press_pulse[i] <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!debounced_signal[i]) begin
                            state_q[i]       <= IDLE;
                            release_pulse[i] <= 1'b1;
                        end else if (tick) begin
                            if (cnt_q[i] + CW'(1) == CW'(LONG_PRESS_TICKS)) begin
                                state_q[i]          <= LONG;
                                cnt_q[i]            <= '0;
                                long_press_pulse[i] <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CW'(1);
                            end
                        end
                    end
                    LONG: begin
                        if (!debounced_signal[i]) begin
                            state_q[i]       <= IDLE;
                            release_pulse[i] <= 1'b1;
                        end
`ifdef BUTTON_AUTOREPEAT_EN
                        else if (tick) begin
                            if (cnt_q[i] + CW'(1) == CW'(REPEAT_TICKS)) begin
                                cnt_q[i]    <= '0;
                                repeat_q[i] <= 1'b1;
                            end else begin
                                cnt_q[i] <= cnt_q[i] + CW'(1);
                            end
                        end
`endif
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - table-driven check of button_event_decoder with WIDTH=2, TICK_CNT_MAX=4, LONG_PRESS_TICKS=3, REPEAT_TICKS=2
module tb_button_event_decoder;

    logic       clk;
    logic       rst_n;
    logic [1:0] debounced_signal;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_press_pulse;
    logic [1:0] repeat_pulse;
    logic [1:0] held;

    int checks   = 0;
    int failures = 0;

    button_event_decoder #(
        .WIDTH            (2),
        .TICK_CNT_MAX     (4),
        .LONG_PRESS_TICKS (3),
        .REPEAT_TICKS     (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .debounced_signal (debounced_signal),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .repeat_pulse     (repeat_pulse),
        .held             (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [1:0] RP0 = 2'b01;
    localparam logic [1:0] RP1 = 2'b10;
`else
    localparam logic [1:0] RP0 = 2'b00;
    localparam logic [1:0] RP1 = 2'b00;
`endif

    typedef struct {
        logic [1:0] din;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
        logic [1:0] rpt;
        logic [1:0] hld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] din, input logic [1:0] press, input logic [1:0] rel,
                       input logic [1:0] lng, input logic [1:0] rpt, input logic [1:0] hld,
                       input int n);
        vec_t v;
        v.din = din; v.press = press; v.rel = rel; v.lng = lng; v.rpt = rpt; v.hld = hld;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] p, input logic [1:0] r,
                             input logic [1:0] l, input logic [1:0] rp, input logic [1:0] h);
        check({tag, " press"},   press_pulse,      p);
        check({tag, " release"}, release_pulse,    r);
        check({tag, " long"},    long_press_pulse, l);
        check({tag, " repeat"},  repeat_pulse,     rp);
        check({tag, " held"},    held,             h);
    endtask

    initial begin
        // Edge numbering: edge 1 is the first rising edge after reset release; ticks fire at edges 4,8,12,...
        // Edges 1-20: idle
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 20);
        // Edges 21-26: ch0 high for 5 cycles
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4);
        add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        // Edges 29-72: ch0 held 40 cycles; long at 40, repeats at 48/56/64, release at 69
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 10);
        add(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 7);
        add(2'b01, 2'b00, 2'b00, 2'b00, RP0,   2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 7);
        add(2'b01, 2'b00, 2'b00, 2'b00, RP0,   2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 7);
        add(2'b01, 2'b00, 2'b00, 2'b00, RP0,   2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 4);
        add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        // Edges 73-85: release exactly on the third tick (edge 84): release only
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 10);
        add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        // Edges 86-104: ch1 held, ch0 toggles every 6 cycles
        add(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 5);
        add(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 1);
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3);
        add(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 1);
        add(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1);
        add(2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 5);
        add(2'b10, 2'b00, 2'b01, 2'b00, RP1,   2'b10, 1);

        rst_n            = 1'b0;
        debounced_signal = 2'b00;
        #1;
        check_all("reset_async", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (3) @(negedge clk);
        check_all("reset_held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            debounced_signal = vecs[i].din;
            @(posedge clk);
            #1;
            check_all($sformatf("edge%0d", i + 1), vecs[i].press, vecs[i].rel,
                      vecs[i].lng, vecs[i].rpt, vecs[i].hld);
            @(negedge clk);
        end

        // Edge 105: ch1 still in LONG, no tick
        debounced_signal = 2'b10;
        @(posedge clk);
        #1;
        check_all("edge105", 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);

        // Asynchronous reset mid-hold: outputs clear without waiting for a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all("midhold_reset_async", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        check_all("midhold_reset_held", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;

        // Ch1 high at reset release: press on first edge, long from a freshly cleared count at edge 12
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("post_reset_edge%0d", e),
                      (e == 1)  ? 2'b10 : 2'b00, 2'b00,
                      (e == 12) ? 2'b10 : 2'b00, 2'b00, 2'b10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Converts per-channel debounced button levels into single-cycle event pulses: press, release, long-press and (optionally) auto-repeat. It sits directly downstream of the debouncer in the I/O circuits path, consuming its `debounced_signal` vector and feeding one-cycle strobes to the MMIO/CPU-visible button registers. Long-press and repeat timing use a shared prescaler tick, so per-channel counters stay narrow.

## Interface
- `WIDTH`, 1: number of button channels.
- `TICK_CNT_MAX`, 125000: prescaler period in `clk` cycles; one tick every `TICK_CNT_MAX` cycles.
- `LONG_PRESS_TICKS`, 1000: ticks of continuous hold before a long-press event.
- `REPEAT_TICKS`, 200: ticks between auto-repeat events once long-pressed.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `debounced_signal`  input  WIDTH  debounced button levels, 1 = pressed; already synchronous to `clk`.
- `press_pulse`  output  WIDTH  one-cycle strobe on a 0→1 level change.
- `release_pulse`  output  WIDTH  one-cycle strobe on a 1→0 level change.
- `long_press_pulse`  output  WIDTH  one-cycle strobe when the hold reaches `LONG_PRESS_TICKS`.
- `repeat_pulse`  output  WIDTH  one-cycle strobe every `REPEAT_TICKS` while in LONG state.
- `held`  output  WIDTH  registered copy of the level, high from the press cycle until release.

## Operation
- Shared prescaler: counts 0..`TICK_CNT_MAX`-1 and wraps. `tick` is high in the cycle where count == `TICK_CNT_MAX`-1. Width is `$clog2(TICK_CNT_MAX)`+1.
- Per channel: `prev` register holding the last sampled level, a hold counter (width `$clog2(max(LONG_PRESS_TICKS,REPEAT_TICKS))`+1), and a state register.
- FSM states: IDLE, PRESSED, LONG.
  - IDLE: `in & ~prev` → PRESSED, counter := 0, `press_pulse`.
  - PRESSED: `~in` → IDLE, `release_pulse`. Otherwise, on `tick`, counter += 1. If counter+1 == `LONG_PRESS_TICKS` → LONG, counter := 0, `long_press_pulse`.
  - LONG: `~in` → IDLE, `release_pulse`. Otherwise, on `tick`, counter += 1. If counter+1 == `REPEAT_TICKS` → counter := 0, `repeat_pulse` (only with the macro; see Configuration).
- Simultaneous release and threshold tick: release wins. No long/repeat pulse is emitted and the state goes to IDLE.
- Channels are fully independent. Any combination of pulses on different bits may occur in the same cycle.
- Per channel, at most one of press/release/long/repeat is high in any cycle.
- Counters saturate-free: they are cleared on every threshold hit and on press, so they never exceed their threshold.

## Timing
- Reset (`rst_n` low, asynchronous): prescaler = 0, all `prev` = 0, all states IDLE, all counters 0. Every output is 0 immediately and stays 0 while reset is asserted.
- Reset release while an input is already high: this counts as a 0→1 edge. `press_pulse` fires on the first clock after deassertion.
- All outputs are registered. An input change sampled at edge k appears on the pulse output during cycle k+1 (latency 1). `held` follows the input with the same latency.
- Long-press latency after `press_pulse`: between (`LONG_PRESS_TICKS`-1)·`TICK_CNT_MAX`+1 and `LONG_PRESS_TICKS`·`TICK_CNT_MAX` cycles. The spread comes from tick phase.
- Repeat spacing: exactly `REPEAT_TICKS`·`TICK_CNT_MAX` cycles between consecutive `repeat_pulse`, and from `long_press_pulse` to the first repeat.
- Reset asserted mid-hold aborts every in-progress count with no pulses emitted.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined: the LONG state counts ticks and emits `repeat_pulse` as specified.
- Not defined: the LONG-state counter logic is removed. `repeat_pulse` is tied to 0 and LONG exits only on release. `REPEAT_TICKS` is ignored, and the counter width uses `LONG_PRESS_TICKS` only.

## Test plan
Parameters for all tests: `WIDTH`=2, `TICK_CNT_MAX`=4, `LONG_PRESS_TICKS`=3, `REPEAT_TICKS`=2.
- Reset with both inputs low, then release reset and hold low 20 cycles → all outputs 0 throughout.
- Ch0 high for 5 cycles, then low → `press_pulse`[0] for 1 cycle at input+1 and `release_pulse`[0] for 1 cycle at fall+1. `held`[0] is high 5 cycles. No long pulse.
- Ch0 held 40 cycles with `BUTTON_AUTOREPEAT_EN` → `long_press_pulse` 9–12 cycles after press, then `repeat_pulse` every 8 cycles, then `release_pulse` once.
- Same as the previous test without the macro → one `long_press_pulse`, `repeat_pulse` never asserted.
- Ch0 released in the exact cycle the 3rd tick would fire → `release_pulse` only, no `long_press_pulse`.
- Ch1 held while ch0 toggles every 6 cycles; then assert `rst_n` low mid-hold → independent pulses per bit; all outputs 0 asynchronously on reset. Ch1 still high at reset release gives `press_pulse`[1] on the next cycle.
